// File: rtl/fp_unit_dispatch_pkg.sv
// Shared FP dispatch types: exception flag struct, queue entry layout and
// default sizing for the per-unit issue queues.
package fpu_types;

    localparam int FP_DISPATCH_DEPTH = 2;
    localparam int FP_DISPATCH_CNT_W = $clog2(FP_DISPATCH_DEPTH) + 1;
    localparam int FP_DISPATCH_PKT_W = 64;
    localparam int FP_DISPATCH_ID_W  = 3;

    // Bit order matches the architectural fflags CSR: NV is the MSB, NX the LSB.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic [FP_DISPATCH_ID_W-1:0]  id;
        logic [FP_DISPATCH_PKT_W-1:0] payload;
    } fp_dispatch_entry_t;

    function automatic fflags_t fflags_or(input fflags_t a, input fflags_t b);
        return fflags_t'(a | b);
    endfunction

endpackage

// File: rtl/fp_unit_dispatch_if.sv
// Bundle of request, per-unit issue, status and writeback-flag signals
// around the FP dispatch stage.
interface fp_unit_dispatch_if #(
    parameter int NUM_UNITS = 5,
    parameter int DEPTH     = 2,
    parameter int PKT_W     = 64,
    parameter int ID_W      = 3,
    parameter int NUM_WB    = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       flush;
    logic                       req_valid;
    logic [NUM_UNITS-1:0]       req_unit;
    logic [PKT_W-1:0]           req_payload;
    logic [ID_W-1:0]            req_id;
    logic [NUM_UNITS-1:0]       unit_ready;
    logic [NUM_UNITS-1:0]       unit_new_request;
    logic [NUM_UNITS-1:0]       unit_accept;
    logic [NUM_UNITS*PKT_W-1:0] unit_payload;
    logic [NUM_UNITS*ID_W-1:0]  unit_id;
    logic [NUM_UNITS*CNT_W-1:0] occupancy;
    logic [NUM_WB-1:0]          wb_done;
    logic [NUM_WB-1:0]          wb_ack;
    logic [NUM_WB*5-1:0]        wb_fflags;
    logic [4:0]                 fflags;
    logic                       protocol_err;

    modport master (
        output flush, req_valid, req_unit, req_payload, req_id, unit_accept,
               wb_done, wb_ack, wb_fflags,
        input  unit_ready, unit_new_request, unit_payload, unit_id, occupancy,
               fflags, protocol_err
    );

    modport slave (
        input  flush, req_valid, req_unit, req_payload, req_id, unit_accept,
               wb_done, wb_ack, wb_fflags,
        output unit_ready, unit_new_request, unit_payload, unit_id, occupancy,
               fflags, protocol_err
    );

endinterface

// File: rtl/fp_unit_dispatch_fifo.sv
// One issue queue: DEPTH-entry FIFO with explicit occupancy, synchronous flush
// and a registered head entry (no push-to-head bypass).
module fp_dispatch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 67,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             accept,
    output logic             ready,
    output logic             new_request,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] occ_reg, occ_next;
    logic [W-1:0]     head_reg, head_next;
    logic             do_push;
    logic             do_pop;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign ready       = (occ_reg != FULL);
    assign do_pop      = (occ_reg != '0) & accept;
    assign do_push     = push & ready;
    assign new_request = do_pop;
    assign head_data   = head_reg;
    assign occupancy   = occ_reg;

    always_comb begin
        occ_next    = occ_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        head_next   = head_reg;

        if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);

        case ({do_push, do_pop})
            2'b10:   occ_next = occ_reg + CNT_W'(1);
            2'b01:   occ_next = occ_reg - CNT_W'(1);
            default: occ_next = occ_reg;
        endcase

        // Head register tracks the entry that will be oldest after this edge.
        if (do_pop) begin
            if (occ_reg > CNT_W'(1))
                head_next = mem[rd_ptr_next];
            else if (do_push)
                head_next = push_data;
        end else if ((occ_reg == '0) && do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            occ_reg    <= occ_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst)
            mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/fp_unit_dispatch.sv
// FP dispatch stage: one independent issue queue per execution unit, request
// legality checking with a sticky error flag, and writeback fflags merging.
module fp_unit_dispatch
    import fpu_types::*;
#(
    parameter int NUM_UNITS = 5,
    parameter int DEPTH     = FP_DISPATCH_DEPTH,
    parameter int PKT_W     = FP_DISPATCH_PKT_W,
    parameter int ID_W      = FP_DISPATCH_ID_W,
    parameter int NUM_WB    = 2
) (
    input logic               clk,
    input logic               rst,
    fp_unit_dispatch_if.slave bus
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ID_W + PKT_W;

    logic [NUM_UNITS-1:0]       ready_vec;
    logic [NUM_UNITS-1:0]       new_req_vec;
    logic [NUM_UNITS-1:0]       push_vec;
    logic [ENTRY_W-1:0]         head_arr [NUM_UNITS];
    logic [CNT_W-1:0]           occ_arr  [NUM_UNITS];
    logic [NUM_UNITS*PKT_W-1:0] payload_flat;
    logic [NUM_UNITS*ID_W-1:0]  id_flat;
    logic [NUM_UNITS*CNT_W-1:0] occ_flat;
    logic                       req_onehot;
    logic                       err_set;
    logic                       err_reg;
    fflags_t                    fflags_merged;

    assign req_onehot = (bus.req_unit != '0) &&
                        ((bus.req_unit & (bus.req_unit - NUM_UNITS'(1))) == '0);

    // Illegal requests are dropped entirely; the queue side only sees legal pushes.
    assign err_set = bus.req_valid &
                     (!req_onehot || ((bus.req_unit & ~ready_vec) != '0));

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_queue
            assign push_vec[gi] = bus.req_valid & req_onehot & bus.req_unit[gi];

            fp_dispatch_fifo #(
                .DEPTH (DEPTH),
                .W     (ENTRY_W),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .flush       (bus.flush),
                .push        (push_vec[gi]),
                .push_data   ({bus.req_id, bus.req_payload}),
                .accept      (bus.unit_accept[gi]),
                .ready       (ready_vec[gi]),
                .new_request (new_req_vec[gi]),
                .head_data   (head_arr[gi]),
                .occupancy   (occ_arr[gi])
            );

            assign payload_flat[gi*PKT_W +: PKT_W] = head_arr[gi][PKT_W-1:0];
            assign id_flat[gi*ID_W +: ID_W]        = head_arr[gi][ENTRY_W-1 -: ID_W];
            assign occ_flat[gi*CNT_W +: CNT_W]     = occ_arr[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (err_set)
            err_reg <= 1'b1;
    end

    always_comb begin
        fflags_merged = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (bus.wb_done[k] && bus.wb_ack[k])
                fflags_merged = fflags_or(fflags_merged, fflags_t'(bus.wb_fflags[k*5 +: 5]));
        end
    end

    assign bus.unit_ready       = ready_vec;
    assign bus.unit_new_request = new_req_vec;
    assign bus.unit_payload     = payload_flat;
    assign bus.unit_id          = id_flat;
    assign bus.occupancy        = occ_flat;
    assign bus.protocol_err     = err_reg;
    assign bus.fflags           = fflags_merged;

endmodule
